alu_result_queue: RTL and testbench

Downstream capture stage for the 8-bit ALU datapath. It registers each ALU result, zero flag and opcode into a small FIFO behind a valid/ready handshake, so a stalled consumer never forces the ALU to hold its operands. Optional statistics track a running sum of accepted results and a count of zero results, for debug and performance monitoring.

---
 rtl/alu_result_queue.sv | 156 +++++++++++++++
 tb/tb_alu_result_queue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_queue.sv
// Result capture FIFO behind the ALU, with valid/ready handshakes on both sides.
// Define ALU_RES_STATS_EN to build the running result sum and zero-result counter.
module alu_result_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_result,
    input  logic            in_zero,
    input  logic [3:0]      in_opcode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_result,
    output logic            out_zero,
    output logic [3:0]      out_opcode,
    input  logic            stats_clr,
    output logic [2*DW-1:0] acc_sum,
    output logic [7:0]      zero_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_LAST = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } occ_state_t;

    occ_state_t state, next_state;

    logic [DW-1:0] res_mem [DEPTH];
    logic          zero_mem [DEPTH];
    logic [3:0]    opc_mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            EMPTY: begin
                if (push) begin
                    next_state = PARTIAL;
                end
            end
            PARTIAL: begin
                if (push && !pop && count == CNT_LAST) begin
                    next_state = FULL;
                end else if (pop && !push && count == CNT_ONE) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    next_state = PARTIAL;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    // Handshake flags come from state alone, so out_ready never reaches in_ready.
    always_comb begin
        in_ready  = (state != FULL);
        out_valid = (state != EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                res_mem[i]  <= '0;
                zero_mem[i] <= 1'b0;
                opc_mem[i]  <= '0;
            end
        end else if (push) begin
            res_mem[wr_ptr]  <= in_result;
            zero_mem[wr_ptr] <= in_zero;
            opc_mem[wr_ptr]  <= in_opcode;
        end
    end

    assign out_result = res_mem[rd_ptr];
    assign out_zero   = zero_mem[rd_ptr];
    assign out_opcode = opc_mem[rd_ptr];

`ifdef ALU_RES_STATS_EN
    logic [2*DW-1:0] acc_sum_q;
    logic [7:0]      zero_cnt_q;

    // A clear wins over a same-cycle push; that word is queued but not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_sum_q  <= '0;
            zero_cnt_q <= '0;
        end else if (stats_clr) begin
            acc_sum_q  <= '0;
            zero_cnt_q <= '0;
        end else if (push) begin
            acc_sum_q <= acc_sum_q + {{DW{1'b0}}, in_result};
            if (in_zero && zero_cnt_q != 8'hFF) begin
                zero_cnt_q <= zero_cnt_q + 8'd1;
            end
        end
    end

    assign acc_sum  = acc_sum_q;
    assign zero_cnt = zero_cnt_q;
`else
    logic unused_stats_clr;

    assign unused_stats_clr = stats_clr;
    assign acc_sum          = '0;
    assign zero_cnt         = '0;
`endif

endmodule

// File: tb/tb_alu_result_queue.sv
// Self-checking bench for alu_result_queue: a queue-based reference model compared every cycle,
// plus directed fill/drain/wrap/statistics/reset scenarios with literal expectations.
module tb_alu_result_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 8;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_result;
    logic          in_zero;
    logic [3:0]    in_opcode;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result;
    logic          out_zero;
    logic [3:0]    out_opcode;
    logic          stats_clr;
    logic [15:0]   acc_sum;
    logic [7:0]    zero_cnt;

    int checks_total;
    int checks_passed;

    alu_result_queue #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_zero    (in_zero),
        .in_opcode  (in_opcode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_opcode (out_opcode),
        .stats_clr  (stats_clr),
        .acc_sum    (acc_sum),
        .zero_cnt   (zero_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of {opcode, zero, result} plus plain-arithmetic statistics.
    logic [12:0] model_q[$];
    logic [15:0] model_sum;
    int          model_zc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
            model_sum = 16'h0;
            model_zc  = 0;
        end else begin
            bit do_push;
            bit do_pop;
            do_push = in_valid && (model_q.size() < DEPTH);
            do_pop  = out_ready && (model_q.size() > 0);
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back({in_opcode, in_zero, in_result});
`ifdef ALU_RES_STATS_EN
            if (stats_clr) begin
                model_sum = 16'h0;
                model_zc  = 0;
            end else if (do_push) begin
                model_sum = model_sum + 16'(in_result);
                if (in_zero && model_zc < 255) model_zc = model_zc + 1;
            end
`endif
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("count", 32'(dut.count), 32'(model_q.size()));
            checkOutput("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
            checkOutput("in_ready", 32'(in_ready), 32'(model_q.size() != DEPTH));
            if (model_q.size() != 0) begin
                checkOutput("head", {19'h0, out_opcode, out_zero, out_result}, {19'h0, model_q[0]});
            end
            checkOutput("acc_sum", 32'(acc_sum), 32'(model_sum));
            checkOutput("zero_cnt", 32'(zero_cnt), 32'(model_zc));
        end
    end

    task automatic applyStimulus(input bit v, input logic [7:0] res, input bit z,
                                 input logic [3:0] opc, input bit ordy, input bit clr);
        in_valid  = v;
        in_result = res;
        in_zero   = z;
        in_opcode = opc;
        out_ready = ordy;
        stats_clr = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] fill_vals [4];
        checks_total  = 0;
        checks_passed = 0;
        fill_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_result = '0;
        in_zero   = 1'b0;
        in_opcode = '0;
        out_ready = 1'b0;
        stats_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_result", 32'(out_result), 32'd0);
        checkOutput("rst_acc_sum", 32'(acc_sum), 32'd0);
        checkOutput("rst_zero_cnt", 32'(zero_cnt), 32'd0);
        rst_n = 1'b1;

        // Fill to DEPTH with the consumer stalled, then try one more.
        for (int i = 0; i < 4; i++) applyStimulus(1, fill_vals[i], 0, 4'(i + 1), 0, 0);
        checkOutput("fill_in_ready", 32'(in_ready), 32'd0);
        applyStimulus(1, 8'h55, 0, 4'h5, 0, 0);
        checkOutput("fill_head_held", 32'(out_result), 32'h11);
        checkOutput("fill_count", 32'(dut.count), 32'd4);

        // Drain in order.
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain_order", 32'(out_result), 32'(fill_vals[i]));
            applyStimulus(0, 8'h00, 0, 4'h0, 1, 0);
        end
        checkOutput("drain_empty", 32'(out_valid), 32'd0);

        // Streaming pushes with a ready consumer wrap both pointers.
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1, 8'(k), 0, 4'(k), 1, 0);
            checkOutput("wrap_head", 32'(out_result), 32'(k));
        end
        applyStimulus(0, 8'h00, 0, 4'h0, 1, 0);
        checkOutput("wrap_empty", 32'(out_valid), 32'd0);

        // Simultaneous push and pop at count 2.
        applyStimulus(1, 8'hA1, 0, 4'h1, 0, 0);
        applyStimulus(1, 8'hA2, 0, 4'h2, 0, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 8'(8'hA3 + k), 0, 4'(k + 3), 1, 0);
            checkOutput("simul_count", 32'(dut.count), 32'd2);
            checkOutput("simul_head", 32'(out_result), 32'(8'hA2 + k));
        end
        applyStimulus(1, 8'hB0, 0, 4'h9, 0, 0);
        applyStimulus(1, 8'hB1, 0, 4'hA, 0, 0);
        in_valid  = 1'b1;
        in_result = 8'hB2;
        out_ready = 1'b1;
        #1;
        checkOutput("full_pop_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("full_pop_count", 32'(dut.count), 32'd3);
        for (int k = 0; k < 3; k++) applyStimulus(0, 8'h00, 0, 4'h0, 1, 0);
        checkOutput("simul_drained", 32'(out_valid), 32'd0);

        // Statistics.
        applyStimulus(0, 8'h00, 0, 4'h0, 1, 1);
        applyStimulus(1, 8'hFF, 0, 4'h1, 1, 0);
        applyStimulus(1, 8'h00, 1, 4'h2, 1, 0);
        applyStimulus(1, 8'h01, 0, 4'h3, 1, 0);
`ifdef ALU_RES_STATS_EN
        checkOutput("stats_sum", 32'(acc_sum), 32'h0100);
        checkOutput("stats_zc", 32'(zero_cnt), 32'd1);
`else
        checkOutput("stats_sum_off", 32'(acc_sum), 32'h0);
        checkOutput("stats_zc_off", 32'(zero_cnt), 32'd0);
`endif
        for (int k = 0; k < 300; k++) applyStimulus(1, 8'h00, 1, 4'h4, 1, 0);
`ifdef ALU_RES_STATS_EN
        checkOutput("stats_zc_sat", 32'(zero_cnt), 32'd255);
`else
        checkOutput("stats_zc_sat_off", 32'(zero_cnt), 32'd0);
`endif
        applyStimulus(0, 8'h00, 0, 4'h0, 1, 0);
        applyStimulus(1, 8'h05, 0, 4'h6, 0, 1);
        checkOutput("clr_sum", 32'(acc_sum), 32'h0);
        checkOutput("clr_zc", 32'(zero_cnt), 32'd0);
        checkOutput("clr_queued_valid", 32'(out_valid), 32'd1);
        checkOutput("clr_queued_data", 32'(out_result), 32'h05);

        // Asynchronous reset with three entries queued.
        applyStimulus(1, 8'h06, 0, 4'h7, 0, 0);
        applyStimulus(1, 8'h07, 0, 4'h8, 0, 0);
        checkOutput("pre_rst_count", 32'(dut.count), 32'd3);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checkOutput("async_out_valid", 32'(out_valid), 32'd0);
        checkOutput("async_in_ready", 32'(in_ready), 32'd1);
        checkOutput("async_acc_sum", 32'(acc_sum), 32'h0);
        #1;
        rst_n = 1'b1;
        applyStimulus(1, 8'h7E, 0, 4'hC, 0, 0);
        checkOutput("post_rst_valid", 32'(out_valid), 32'd1);
        checkOutput("post_rst_head", 32'(out_result), 32'h7E);
        applyStimulus(0, 8'h00, 0, 4'h0, 1, 0);
        applyStimulus(0, 8'h00, 0, 4'h0, 0, 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
